reg_wb_queue: RTL and testbench
===============================

REG_WB_QUEUE -- requirements
Module: reg_wb_queue

Interface
REQ-001 The block SHALL expose parameter DEPTH, default 4, the number of pending write-back entries (power of two, 2..8).
REQ-002 The block SHALL have port CLK, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1 bit, reset; reset is synchronous and active-low.
REQ-004 The block SHALL have port WB_VALID, input, 1 bit, producer offers a write-back entry.
REQ-005 The block SHALL have port WB_READY, output, 1 bit, queue can accept an entry this cycle.
REQ-006 The block SHALL have port WB_DATA, input, 8 bits, result value to write.
REQ-007 The block SHALL have port WB_ADDR, input, 3 bits, destination register index.
REQ-008 The block SHALL have port HOLD, input, 1 bit, pause draining without losing entries.
REQ-009 The block SHALL have port FLUSH, input, 1 bit, discard all pending and in-flight entries.
REQ-010 The block SHALL have port RF_IN, output, 8 bits, data to the register-file write port.
REQ-011 The block SHALL have port RF_INADDRESS, output, 3 bits, register-file write index.
REQ-012 The block SHALL have port RF_WRITE, output, 1 bit, register-file write enable.
REQ-013 The block SHALL have port LOOKUP_ADDR, input, 3 bits, register index probed for forwarding.
REQ-014 The block SHALL have port LOOKUP_HIT, output, 1 bit, a pending or in-flight write targets LOOKUP_ADDR.
REQ-015 The block SHALL have port LOOKUP_DATA, output, 8 bits, value of the youngest matching write; 0 when no hit.
REQ-016 The block SHALL have port COUNT, output, 4 bits, number of entries queued (excluding the output stage).

Function
REQ-017 Storage SHALL be a circular FIFO of DEPTH entries {data[7:0], addr[2:0]} with head/tail pointers wrapping modulo DEPTH.
REQ-018 WB_READY SHALL be combinational: high iff COUNT < DEPTH and FLUSH is low; it SHALL NOT depend on WB_VALID.
REQ-019 An entry SHALL be enqueued at the rising edge when WB_VALID and WB_READY are both high.
REQ-020 Drain: at each rising edge with COUNT > 0, HOLD low and FLUSH low, the head entry SHALL be popped into registered RF_IN/RF_INADDRESS with RF_WRITE set high for exactly that cycle.
REQ-021 When no pop occurs, RF_WRITE SHALL be 0 the following cycle; RF_IN/RF_INADDRESS SHALL hold their last values.
REQ-022 Latency: an entry accepted into an empty queue at edge N SHALL appear with RF_WRITE high after edge N+1; the register file commits it at edge N+2.
REQ-023 A simultaneous push and pop SHALL leave COUNT unchanged; push when full SHALL NOT occur because WB_READY is low, even if a pop happens in the same cycle.
REQ-024 Entries SHALL drain in strict acceptance order; two entries with the same WB_ADDR SHALL both be written, older first.
REQ-025 FLUSH high at an edge SHALL clear COUNT to 0, reset both pointers, and force RF_WRITE to 0 the following cycle; FLUSH takes priority over push, pop and HOLD.
REQ-026 HOLD high SHALL suppress pops only; enqueues continue until full.
REQ-027 LOOKUP SHALL be combinational, searching queued entries youngest-first, then the output stage if RF_WRITE is high; the first match SHALL drive LOOKUP_HIT=1 and LOOKUP_DATA.
REQ-028 LOOKUP_HIT SHALL be 0 when COUNT = 0 and RF_WRITE = 0.

Reset
REQ-029 With RESET low at a rising edge: COUNT=0, pointers=0, RF_WRITE=0, RF_IN=0, RF_INADDRESS=0; RESET takes priority over FLUSH, push and pop.
REQ-030 While RESET is low, WB_READY SHALL be 0 and LOOKUP_HIT SHALL be 0; a mid-drain reset discards all entries and no further RF_WRITE pulse follows.

Verification
REQ-031 Single write: push {0x5A, r3} into empty queue -> RF_WRITE=1, RF_IN=0x5A, RF_INADDRESS=3 for exactly one cycle, one cycle after acceptance.
REQ-032 Fill/back-pressure: HOLD=1, push 5 entries -> first 4 accepted, WB_READY=0, COUNT=4; release HOLD -> 4 consecutive RF_WRITE pulses in order, COUNT reaches 0, WB_READY returns to 1.
REQ-033 Forwarding: queue {0x11,r2} then {0x22,r2}, LOOKUP_ADDR=2 -> LOOKUP_HIT=1, LOOKUP_DATA=0x22; LOOKUP_ADDR=5 -> LOOKUP_HIT=0, LOOKUP_DATA=0.
REQ-034 Flush: 3 entries queued, FLUSH pulsed one cycle -> COUNT=0, RF_WRITE=0 thereafter, WB_READY low during FLUSH cycle only.
REQ-035 Wrap-around: 10 back-to-back pushes with draining enabled -> 10 RF_WRITE pulses, data/addr in order, COUNT never exceeds 1.
REQ-036 Reset mid-drain: 4 entries queued, drain started, RESET low one cycle -> all outputs 0, no further RF_WRITE pulses.

Source files
------------

// File: rtl/reg_wb_queue.sv
// Register write-back queue: a circular FIFO of pending {data, addr} writes that
// drains one entry per cycle into a registered register-file write port, with forwarding lookup.
module reg_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       WB_VALID,
  output logic       WB_READY,
  input  logic [7:0] WB_DATA,
  input  logic [2:0] WB_ADDR,
  input  logic       HOLD,
  input  logic       FLUSH,
  output logic [7:0] RF_IN,
  output logic [2:0] RF_INADDRESS,
  output logic       RF_WRITE,
  input  logic [2:0] LOOKUP_ADDR,
  output logic       LOOKUP_HIT,
  output logic [7:0] LOOKUP_DATA,
  output logic [3:0] COUNT
);

  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  logic [7:0]    data_mem_q [DEPTH];
  logic [2:0]    addr_mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [3:0]    count_q, count_d;
  logic [7:0]    rf_data_q, rf_data_d;
  logic [2:0]    rf_addr_q, rf_addr_d;
  logic          rf_write_q, rf_write_d;
  logic          push, pop;
  logic [PW-1:0] lk_idx;

  // Ready ignores WB_VALID so the producer can decide to offer based on it.
  assign WB_READY = RESET && (count_q < DEPTH_C) && !FLUSH;
  assign push     = WB_VALID && WB_READY;
  assign pop      = (count_q != 4'd0) && !HOLD && !FLUSH;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    rf_data_d  = rf_data_q;
    rf_addr_d  = rf_addr_q;
    rf_write_d = 1'b0;
    if (FLUSH) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = 4'd0;
    end else begin
      if (push) tail_d = tail_q + PW'(1);
      if (pop) begin
        head_d     = head_q + PW'(1);
        rf_data_d  = data_mem_q[head_q];
        rf_addr_d  = addr_mem_q[head_q];
        rf_write_d = 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 4'd1;
        2'b01:   count_d = count_q - 4'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= 4'd0;
      rf_data_q  <= 8'd0;
      rf_addr_q  <= 3'd0;
      rf_write_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rf_data_q  <= rf_data_d;
      rf_addr_q  <= rf_addr_d;
      rf_write_q <= rf_write_d;
    end
  end

  // NOTE: storage is not reset; an entry is only ever read while count_q marks it valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      data_mem_q[tail_q] <= WB_DATA;
      addr_mem_q[tail_q] <= WB_ADDR;
    end
  end

  // Output stage is the oldest candidate; queued entries are scanned oldest to youngest so the youngest match wins.
  always_comb begin
    LOOKUP_HIT  = 1'b0;
    LOOKUP_DATA = 8'd0;
    lk_idx      = '0;
    if (RESET) begin
      if (rf_write_q && (rf_addr_q == LOOKUP_ADDR)) begin
        LOOKUP_HIT  = 1'b1;
        LOOKUP_DATA = rf_data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        lk_idx = head_q + PW'(i);
        if ((4'(i) < count_q) && (addr_mem_q[lk_idx] == LOOKUP_ADDR)) begin
          LOOKUP_HIT  = 1'b1;
          LOOKUP_DATA = data_mem_q[lk_idx];
        end
      end
    end
  end

  assign RF_IN        = rf_data_q;
  assign RF_INADDRESS = rf_addr_q;
  assign RF_WRITE     = rf_write_q;
  assign COUNT        = count_q;

endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed bench for reg_wb_queue: reset, single write, back-pressure, forwarding,
// flush, wrap-around and mid-drain reset, with hand-computed expectations.
module tb_reg_wb_queue;

  logic       CLK = 1'b0;
  logic       RESET, WB_VALID, WB_READY, HOLD, FLUSH;
  logic [7:0] WB_DATA, RF_IN, LOOKUP_DATA;
  logic [2:0] WB_ADDR, RF_INADDRESS, LOOKUP_ADDR;
  logic       RF_WRITE, LOOKUP_HIT;
  logic [3:0] COUNT;

  int total = 0;
  int bad   = 0;
  int pulses;

  reg_wb_queue #(.DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .WB_VALID(WB_VALID), .WB_READY(WB_READY),
    .WB_DATA(WB_DATA), .WB_ADDR(WB_ADDR), .HOLD(HOLD), .FLUSH(FLUSH),
    .RF_IN(RF_IN), .RF_INADDRESS(RF_INADDRESS), .RF_WRITE(RF_WRITE),
    .LOOKUP_ADDR(LOOKUP_ADDR), .LOOKUP_HIT(LOOKUP_HIT), .LOOKUP_DATA(LOOKUP_DATA),
    .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b0; WB_VALID = 1'b0; WB_DATA = 8'd0; WB_ADDR = 3'd0;
    HOLD = 1'b0; FLUSH = 1'b0; LOOKUP_ADDR = 3'd0;
    tick();
    tick();
    check("rst_count", COUNT, 0);
    check("rst_rfw", RF_WRITE, 0);
    check("rst_rfin", RF_IN, 0);
    check("rst_rfaddr", RF_INADDRESS, 0);
    check("rst_ready", WB_READY, 0);
    check("rst_hit", LOOKUP_HIT, 0);
    RESET = 1'b1;
    #1;
    check("post_rst_ready", WB_READY, 1);

    // Single write
    WB_VALID = 1'b1; WB_DATA = 8'h5A; WB_ADDR = 3'd3;
    tick();
    WB_VALID = 1'b0; LOOKUP_ADDR = 3'd3;
    #1;
    check("sw_count", COUNT, 1);
    check("sw_rfw_early", RF_WRITE, 0);
    check("sw_hit_q", LOOKUP_HIT, 1);
    check("sw_data_q", LOOKUP_DATA, 8'h5A);
    tick();
    check("sw_rfw", RF_WRITE, 1);
    check("sw_rfin", RF_IN, 8'h5A);
    check("sw_rfaddr", RF_INADDRESS, 3);
    check("sw_count0", COUNT, 0);
    check("sw_hit_out", LOOKUP_HIT, 1);
    tick();
    check("sw_rfw_off", RF_WRITE, 0);
    check("sw_rfin_hold", RF_IN, 8'h5A);
    check("sw_hit_gone", LOOKUP_HIT, 0);

    // Fill with HOLD, fifth offer refused
    HOLD = 1'b1;
    for (int i = 0; i < 5; i++) begin
      WB_VALID = 1'b1; WB_DATA = 8'h10 + 8'(i); WB_ADDR = 3'(i);
      #1;
      check("fill_ready", WB_READY, (i < 4) ? 1 : 0);
      tick();
      check("fill_no_rfw", RF_WRITE, 0);
    end
    WB_VALID = 1'b0;
    check("fill_count", COUNT, 4);
    check("fill_ready_full", WB_READY, 0);
    HOLD = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain_rfw", RF_WRITE, 1);
      check("drain_rfin", RF_IN, 8'h10 + 8'(i));
      check("drain_rfaddr", RF_INADDRESS, 16'(i));
      check("drain_count", COUNT, 16'(3 - i));
    end
    tick();
    check("drain_rfw_off", RF_WRITE, 0);
    check("drain_ready", WB_READY, 1);

    // Forwarding: youngest of two same-address writes wins
    HOLD = 1'b1;
    WB_VALID = 1'b1; WB_DATA = 8'h11; WB_ADDR = 3'd2;
    tick();
    WB_DATA = 8'h22; WB_ADDR = 3'd2;
    tick();
    WB_VALID = 1'b0; LOOKUP_ADDR = 3'd2;
    #1;
    check("fwd_hit", LOOKUP_HIT, 1);
    check("fwd_data", LOOKUP_DATA, 8'h22);
    LOOKUP_ADDR = 3'd5;
    #1;
    check("fwd_miss_hit", LOOKUP_HIT, 0);
    check("fwd_miss_data", LOOKUP_DATA, 0);

    // Flush with three entries queued
    WB_VALID = 1'b1; WB_DATA = 8'h33; WB_ADDR = 3'd4;
    tick();
    WB_VALID = 1'b0;
    check("fl_count3", COUNT, 3);
    FLUSH = 1'b1;
    #1;
    check("fl_ready_low", WB_READY, 0);
    tick();
    FLUSH = 1'b0;
    #1;
    check("fl_count", COUNT, 0);
    check("fl_rfw", RF_WRITE, 0);
    check("fl_ready_back", WB_READY, 1);
    HOLD = 1'b0; LOOKUP_ADDR = 3'd2;
    tick();
    check("fl_rfw_after", RF_WRITE, 0);
    check("fl_count_after", COUNT, 0);
    check("fl_hit", LOOKUP_HIT, 0);

    // Wrap-around: ten back-to-back pushes while draining
    for (int i = 0; i < 10; i++) begin
      WB_VALID = 1'b1; WB_DATA = 8'hA0 + 8'(i); WB_ADDR = 3'((i * 3) % 8);
      tick();
      check("wr_count", COUNT, 1);
      if (i > 0) begin
        check("wr_rfw", RF_WRITE, 1);
        check("wr_rfin", RF_IN, 8'hA0 + 8'(i - 1));
        check("wr_rfaddr", RF_INADDRESS, 16'(((i - 1) * 3) % 8));
      end else begin
        check("wr_rfw_first", RF_WRITE, 0);
      end
    end
    WB_VALID = 1'b0;
    tick();
    check("wr_last_rfw", RF_WRITE, 1);
    check("wr_last_rfin", RF_IN, 8'hA9);
    check("wr_last_rfaddr", RF_INADDRESS, 16'((9 * 3) % 8));
    check("wr_count0", COUNT, 0);
    tick();
    check("wr_rfw_off", RF_WRITE, 0);

    // Reset in the middle of a drain
    HOLD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      WB_VALID = 1'b1; WB_DATA = 8'hB0 + 8'(i); WB_ADDR = 3'(i);
      tick();
    end
    WB_VALID = 1'b0; HOLD = 1'b0;
    tick();
    check("rmd_rfw", RF_WRITE, 1);
    check("rmd_rfin", RF_IN, 8'hB0);
    RESET = 1'b0; LOOKUP_ADDR = 3'd1;
    #1;
    check("rmd_ready", WB_READY, 0);
    check("rmd_hit", LOOKUP_HIT, 0);
    tick();
    check("rmd_count", COUNT, 0);
    check("rmd_rfw0", RF_WRITE, 0);
    check("rmd_rfin0", RF_IN, 0);
    check("rmd_rfaddr0", RF_INADDRESS, 0);
    RESET = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (RF_WRITE === 1'b1) pulses++;
    end
    check("rmd_no_pulses", 16'(pulses), 0);
    check("rmd_count_end", COUNT, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
